control_pipeline_vec: RTL and testbench

- Central pipeline sequencer for the vector processor.
- Decodes the instruction held in IF/ID and generates enable, flush and bubble controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects RAW hazards and sequences multi-cycle vector operations through the EXE lanes.
- Freezes the pipeline while the data-memory handshake is pending, and flushes on taken branches.

---
 rtl/control_pipeline_vec.sv | 183 ++++++++++++++++++
 tb/tb_control_pipeline_vec.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_pipeline_vec.sv
// Pipeline sequencer for the vector processor: decodes IF/ID, detects RAW
// hazards, steps multi-beat vector ALU ops through EXE, freezes on pending
// data-memory accesses and flushes on taken branches.
module control_pipeline_vec #(
    parameter int unsigned VLEN  = 8,
    parameter int unsigned LANES = 2,
    parameter int unsigned IW    = 14
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [IW-1:0]                               instruction_id,
    input  logic [2:0]                                  ex_rd,
    input  logic                                        ex_wr,
    input  logic                                        ex_v,
    input  logic [2:0]                                  mem_rd,
    input  logic                                        mem_wr_reg,
    input  logic                                        mem_v,
    input  logic                                        ex_branch_taken,
    input  logic                                        mem_req,
    input  logic                                        mem_ack,
    output logic                                        pc_en,
    output logic                                        if_id_en,
    output logic                                        if_id_flush,
    output logic                                        id_ex_en,
    output logic                                        id_ex_bubble,
    output logic                                        ex_mem_en,
    output logic                                        mem_wb_en,
    output logic                                        vec_busy,
    output logic [((VLEN > 1) ? $clog2(VLEN) : 1)-1:0]  vec_elem_idx,
    output logic [7:0]                                  stall_cnt
);

    localparam int unsigned IDXW = (VLEN > 1) ? $clog2(VLEN) : 1;
    localparam logic [IDXW-1:0] LANE_STEP = IDXW'(LANES);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(VLEN - LANES);
    localparam bit MULTI_BEAT = (VLEN > LANES);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_VEC      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            save_vec, save_vec_nxt;
    logic            br_pending, br_pending_nxt;
    logic            busy_nxt;
    logic [IDXW-1:0] idx_nxt;

    // Instruction fields
    logic [3:0] opcode;
    logic [2:0] rd, rs1, rs2;
    logic       v;

    assign opcode = instruction_id[13:10];
    assign rd     = instruction_id[9:7];
    assign rs1    = instruction_id[6:4];
    assign rs2    = instruction_id[3:1];
    assign v      = instruction_id[0];

    logic is_alu, is_load, is_store, is_branch;
    logic use_rs1, use_rs2, use_rd;
    logic raw_hazard, vec_alu, freeze, eff_vec, redirect;

    // Decode and source-usage classification
    always_comb begin
        is_alu    = (opcode >= 4'h1) && (opcode <= 4'h7);
        is_load   = (opcode == 4'h8);
        is_store  = (opcode == 4'h9);
        is_branch = (opcode == 4'hA);
        use_rs1   = is_alu || is_load || is_store || is_branch;
        use_rs2   = is_alu || is_branch;
        use_rd    = is_store;
        vec_alu   = is_alu && v;
    end

    // A source hazards against an older writer in the same file; reg 0 never does
    function automatic logic src_hazard(input logic [2:0] src, input logic file_v,
                                        input logic [2:0] e_rd, input logic e_wr,
                                        input logic e_v, input logic [2:0] m_rd,
                                        input logic m_wr, input logic m_v);
        logic hit_ex, hit_mem;
        hit_ex  = e_wr && (e_v == file_v) && (src == e_rd);
        hit_mem = m_wr && (m_v == file_v) && (src == m_rd);
        return (src != 3'd0) && (hit_ex || hit_mem);
    endfunction

    // RAW hazard detection over all used sources
    always_comb begin
        raw_hazard = (use_rs1 && src_hazard(rs1, v, ex_rd, ex_wr, ex_v, mem_rd, mem_wr_reg, mem_v))
                  || (use_rs2 && src_hazard(rs2, v, ex_rd, ex_wr, ex_v, mem_rd, mem_wr_reg, mem_v))
                  || (use_rd  && src_hazard(rd,  v, ex_rd, ex_wr, ex_v, mem_rd, mem_wr_reg, mem_v));
    end

    // State register and sequencing counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            save_vec     <= 1'b0;
            br_pending   <= 1'b0;
            vec_busy     <= 1'b0;
            vec_elem_idx <= '0;
        end else begin
            state        <= state_nxt;
            save_vec     <= save_vec_nxt;
            br_pending   <= br_pending_nxt;
            vec_busy     <= busy_nxt;
            vec_elem_idx <= idx_nxt;
        end
    end

    // Next-state and pipeline control generation
    always_comb begin
        pc_en          = 1'b1;
        if_id_en       = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_en       = 1'b1;
        id_ex_bubble   = 1'b0;
        ex_mem_en      = 1'b1;
        mem_wb_en      = 1'b1;
        state_nxt      = state;
        save_vec_nxt   = save_vec;
        br_pending_nxt = br_pending;
        busy_nxt       = vec_busy;
        idx_nxt        = vec_elem_idx;

        freeze   = mem_req && !mem_ack;
        // On the ack cycle MEM_WAIT behaves as the state it interrupted
        eff_vec  = (state == ST_VEC) || ((state == ST_MEM_WAIT) && save_vec);
        redirect = ex_branch_taken || br_pending;

        if (freeze) begin
            pc_en          = 1'b0;
            if_id_en       = 1'b0;
            id_ex_en       = 1'b0;
            ex_mem_en      = 1'b0;
            mem_wb_en      = 1'b0;
            state_nxt      = ST_MEM_WAIT;
            br_pending_nxt = br_pending || ex_branch_taken;
            if (state != ST_MEM_WAIT) begin
                save_vec_nxt = (state == ST_VEC);
            end
        end else begin
            br_pending_nxt = 1'b0;
            state_nxt      = eff_vec ? ST_VEC : ST_RUN;

            if (redirect) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (eff_vec || raw_hazard) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
            end

            if (eff_vec) begin
                // The older vector op keeps stepping even across a branch flush
                if (vec_elem_idx == LAST_IDX) begin
                    state_nxt = ST_RUN;
                    idx_nxt   = '0;
                    busy_nxt  = 1'b0;
                end else begin
                    idx_nxt = vec_elem_idx + LANE_STEP;
                end
            end else if (!redirect && !raw_hazard && vec_alu && MULTI_BEAT) begin
                // Beat 0 issues with the instruction; the sequencer covers the rest
                state_nxt = ST_VEC;
                idx_nxt   = LANE_STEP;
                busy_nxt  = 1'b1;
            end
        end
    end

    // Saturating debug count of cycles without a PC update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 8'd0;
        end else if (!pc_en && (stall_cnt != 8'hFF)) begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_control_pipeline_vec.sv
// Table-driven bench for control_pipeline_vec (VLEN=8, LANES=2).
module tb_control_pipeline_vec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] instruction_id;
    logic [2:0]  ex_rd, mem_rd;
    logic        ex_wr, ex_v, mem_wr_reg, mem_v;
    logic        ex_branch_taken, mem_req, mem_ack;
    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
    logic        ex_mem_en, mem_wb_en, vec_busy;
    logic [2:0]  vec_elem_idx;
    logic [7:0]  stall_cnt;

    int n_applied = 0;
    int n_miss    = 0;

    always #5 clk = ~clk;

    control_pipeline_vec #(.VLEN(8), .LANES(2), .IW(14)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instruction_id (instruction_id),
        .ex_rd          (ex_rd),
        .ex_wr          (ex_wr),
        .ex_v           (ex_v),
        .mem_rd         (mem_rd),
        .mem_wr_reg     (mem_wr_reg),
        .mem_v          (mem_v),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .if_id_flush    (if_id_flush),
        .id_ex_en       (id_ex_en),
        .id_ex_bubble   (id_ex_bubble),
        .ex_mem_en      (ex_mem_en),
        .mem_wb_en      (mem_wb_en),
        .vec_busy       (vec_busy),
        .vec_elem_idx   (vec_elem_idx),
        .stall_cnt      (stall_cnt)
    );

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en}
    localparam logic [6:0] NORM = 7'b1101011;
    localparam logic [6:0] STL  = 7'b0001111;
    localparam logic [6:0] FRZ  = 7'b0000000;
    localparam logic [6:0] BRF  = 7'b1111111;

    typedef struct {
        logic [13:0] instr;
        logic [2:0]  exrd;
        logic        exwr, exv;
        logic [2:0]  memrd;
        logic        memwr, memv, br, mreq, mack;
        logic [6:0]  ctrl;
        logic        busy;
        logic [2:0]  idx;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [13:0] ins(input int op, input int d, input int s1, input int s2, input int vv);
        return {4'(op), 3'(d), 3'(s1), 3'(s2), 1'(vv)};
    endfunction

    function automatic vec_t mkv(input logic [13:0] instr, input int exrd, input int exwr, input int exv,
                                 input int memrd, input int memwr, input int memv, input int br,
                                 input int mreq, input int mack, input logic [6:0] ctrl,
                                 input int busy, input int idx);
        vec_t r;
        r.instr = instr;   r.exrd = 3'(exrd);   r.exwr = 1'(exwr);   r.exv = 1'(exv);
        r.memrd = 3'(memrd); r.memwr = 1'(memwr); r.memv = 1'(memv); r.br = 1'(br);
        r.mreq = 1'(mreq); r.mack = 1'(mack);   r.ctrl = ctrl;
        r.busy = 1'(busy); r.idx = 3'(idx);
        return r;
    endfunction

    function automatic logic [6:0] ctrl_now();
        return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en};
    endfunction

    task automatic drive(input vec_t r);
        instruction_id  = r.instr;
        ex_rd           = r.exrd;
        ex_wr           = r.exwr;
        ex_v            = r.exv;
        mem_rd          = r.memrd;
        mem_wr_reg      = r.memwr;
        mem_v           = r.memv;
        ex_branch_taken = r.br;
        mem_req         = r.mreq;
        mem_ack         = r.mack;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_applied++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bounded overall runtime
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [13:0] nopi, valu, salu, haz3, r0i, st5, ld5, opf;
        vec_t clr;
        nopi = 14'd0;
        valu = ins(1, 1, 2, 3, 1);
        salu = ins(2, 4, 5, 6, 0);
        haz3 = ins(3, 1, 3, 6, 0);
        r0i  = ins(4, 1, 0, 5, 0);
        st5  = ins(9, 5, 1, 2, 0);
        ld5  = ins(8, 5, 1, 5, 0);
        opf  = ins(15, 1, 3, 3, 0);
        clr  = mkv(nopi, 0,0,0, 0,0,0, 0, 0,0, NORM, 0, 0);

        // Sequential vectors: each row is one clock cycle
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 0, 0,0, NORM, 0, 0));
        tbl.push_back(mkv(valu, 0,0,0, 0,0,0, 0, 0,0, NORM, 0, 0));
        tbl.push_back(mkv(salu, 0,0,0, 0,0,0, 0, 0,0, STL,  1, 2));
        tbl.push_back(mkv(salu, 0,0,0, 0,0,0, 0, 0,0, STL,  1, 4));
        tbl.push_back(mkv(salu, 0,0,0, 0,0,0, 0, 0,0, STL,  1, 6));
        tbl.push_back(mkv(salu, 0,0,0, 0,0,0, 0, 0,0, NORM, 0, 0));
        tbl.push_back(mkv(haz3, 3,1,0, 0,0,0, 0, 0,0, STL,  0, 0));
        tbl.push_back(mkv(haz3, 0,0,0, 3,1,0, 0, 0,0, STL,  0, 0));
        tbl.push_back(mkv(haz3, 0,0,0, 0,0,0, 0, 0,0, NORM, 0, 0));
        tbl.push_back(mkv(haz3, 3,1,1, 0,0,0, 0, 0,0, NORM, 0, 0));
        tbl.push_back(mkv(r0i,  0,1,0, 0,0,0, 0, 0,0, NORM, 0, 0));
        tbl.push_back(mkv(st5,  0,0,0, 5,1,0, 0, 0,0, STL,  0, 0));
        tbl.push_back(mkv(ld5,  5,1,0, 0,0,0, 0, 0,0, NORM, 0, 0));
        tbl.push_back(mkv(opf,  3,1,0, 0,0,0, 0, 0,0, NORM, 0, 0));
        tbl.push_back(mkv(haz3, 3,1,0, 0,0,0, 1, 0,0, BRF,  0, 0));
        tbl.push_back(mkv(haz3, 3,1,0, 0,0,0, 0, 0,0, STL,  0, 0));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 0, 0,0, NORM, 0, 0));
        tbl.push_back(mkv(valu, 0,0,0, 0,0,0, 0, 0,0, NORM, 0, 0));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 0, 0,0, STL,  1, 2));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 0, 1,0, FRZ,  1, 4));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 0, 1,0, FRZ,  1, 4));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 0, 1,0, FRZ,  1, 4));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 0, 1,1, STL,  1, 4));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 0, 0,0, STL,  1, 6));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 0, 0,0, NORM, 0, 0));
        tbl.push_back(mkv(valu, 0,0,0, 0,0,0, 0, 0,0, NORM, 0, 0));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 1, 0,0, BRF,  1, 2));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 0, 0,0, STL,  1, 4));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 0, 0,0, STL,  1, 6));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 0, 0,0, NORM, 0, 0));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 1, 1,0, FRZ,  0, 0));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 0, 0,0, BRF,  0, 0));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 0, 0,0, NORM, 0, 0));
        tbl.push_back(mkv(haz3, 3,1,0, 0,0,0, 0, 1,0, FRZ,  0, 0));
        tbl.push_back(mkv(haz3, 3,1,0, 0,0,0, 0, 0,0, STL,  0, 0));
        tbl.push_back(mkv(haz3, 0,0,0, 0,0,0, 0, 0,0, NORM, 0, 0));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 0, 1,0, FRZ,  0, 0));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 0, 1,1, NORM, 0, 0));
        tbl.push_back(mkv(valu, 2,1,1, 0,0,0, 0, 0,0, STL,  0, 0));
        tbl.push_back(mkv(valu, 0,0,0, 0,0,0, 0, 0,0, NORM, 0, 0));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 0, 0,0, STL,  1, 2));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 0, 0,0, STL,  1, 4));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 0, 0,0, STL,  1, 6));
        tbl.push_back(mkv(nopi, 0,0,0, 0,0,0, 0, 0,0, NORM, 0, 0));

        // Reset state
        rst_n = 1'b0;
        drive(clr);
        #1;
        chk("reset_ctrl", int'(ctrl_now()), int'(NORM));
        chk("reset_busy_idx_cnt", int'({vec_busy, vec_elem_idx, stall_cnt}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            n_applied++;
            if ({ctrl_now(), vec_busy, vec_elem_idx} !== {tbl[i].ctrl, tbl[i].busy, tbl[i].idx}) begin
                n_miss++;
                $display("FAIL row%0d: ctrl=%b busy=%b idx=%0d expected ctrl=%b busy=%b idx=%0d",
                         i, ctrl_now(), vec_busy, vec_elem_idx, tbl[i].ctrl, tbl[i].busy, tbl[i].idx);
            end
        end

        // Asynchronous reset in the middle of a vector sequence
        @(negedge clk);
        drive(mkv(valu, 0,0,0, 0,0,0, 0, 0,0, NORM, 0, 0));
        @(negedge clk);
        drive(clr);
        @(negedge clk);
        #1;
        chk("midvec_idx", int'(vec_elem_idx), 4);
        rst_n = 1'b0;
        #1;
        chk("midvec_reset_idx", int'(vec_elem_idx), 0);
        chk("midvec_reset_busy", int'(vec_busy), 0);
        chk("midvec_reset_cnt", int'(stall_cnt), 0);
        chk("midvec_reset_ctrl", int'(ctrl_now()), int'(NORM));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_ctrl", int'(ctrl_now()), int'(NORM));

        // Stall counter counts then saturates under a persistent hazard
        @(negedge clk);
        drive(mkv(haz3, 3,1,0, 0,0,0, 0, 0,0, STL, 0, 0));
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        chk("stall_cnt_10", int'(stall_cnt), 10);
        repeat (300) @(posedge clk);
        @(negedge clk);
        #1;
        chk("stall_cnt_sat", int'(stall_cnt), 255);
        chk("stall_ctrl", int'(ctrl_now()), int'(STL));
        drive(clr);
        @(negedge clk);
        #1;
        chk("stall_cnt_hold", int'(stall_cnt), 255);
        chk("release_ctrl", int'(ctrl_now()), int'(NORM));

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
